// File: rtl/display_timing_gen.sv
// VGA raster timing generator: pixel-rate clock enable, h/v position counters,
// and registered sync / video-active / frame-start outputs aligned to the position.
module display_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixTick,
  output logic [9:0] pixCol,
  output logic [9:0] pixRow,
  output logic       horizSync,
  output logic       vertSync,
  output logic       videoOn,
  output logic       frameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_LAST     = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic       SYNC_ON      = 1'(SYNC_ACTIVE);
  localparam logic       SYNC_OFF     = ~SYNC_ON;

  function automatic logic inWindow(input logic [9:0] value,
                                    input logic [9:0] first,
                                    input logic [9:0] last);
    return (value >= first) && (value <= last);
  endfunction

  logic [3:0] divCnt_r;
  logic [3:0] divNext_s;
  logic       advance_s;
  logic [9:0] hCnt_r;
  logic [9:0] vCnt_r;
  logic [9:0] hNext_s;
  logic [9:0] vNext_s;

  // Pixel-rate enable and the raster position that takes effect on the next edge
  always_comb begin
    advance_s = (divCnt_r == DIV_LAST);
    divNext_s = divCnt_r;
    hNext_s   = hCnt_r;
    vNext_s   = vCnt_r;
    if (advance_s) begin
      divNext_s = 4'd0;
      if (hCnt_r == H_LAST) begin
        hNext_s = 10'd0;
        if (vCnt_r == V_LAST) begin
          vNext_s = 10'd0;
        end else begin
          vNext_s = vCnt_r + 10'd1;
        end
      end else begin
        hNext_s = hCnt_r + 10'd1;
      end
    end else begin
      divNext_s = divCnt_r + 4'd1;
    end
  end

  // Divider and position counters; reset parks on the last pixel so the first advance lands on (0,0)
  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt_r <= 4'd0;
      hCnt_r   <= H_LAST;
      vCnt_r   <= V_LAST;
    end else begin
      divCnt_r <= divNext_s;
      hCnt_r   <= hNext_s;
      vCnt_r   <= vNext_s;
    end
  end

  // Decoded outputs, registered from the next position so they line up with pixCol/pixRow
  always_ff @(posedge clk) begin
    if (reset) begin
      pixTick    <= 1'b0;
      frameStart <= 1'b0;
      videoOn    <= 1'b0;
      horizSync  <= SYNC_OFF;
      vertSync   <= SYNC_OFF;
    end else if (advance_s) begin
      pixTick    <= 1'b1;
      frameStart <= (hNext_s == 10'd0) && (vNext_s == 10'd0);
      videoOn    <= (hNext_s < H_VIS) && (vNext_s < V_VIS);
      horizSync  <= inWindow(hNext_s, H_SYNC_FIRST, H_SYNC_LAST) ? SYNC_ON : SYNC_OFF;
      vertSync   <= inWindow(vNext_s, V_SYNC_FIRST, V_SYNC_LAST) ? SYNC_ON : SYNC_OFF;
    end else begin
      pixTick    <= 1'b0;
      frameStart <= 1'b0;
    end
  end

  assign pixCol = hCnt_r;
  assign pixRow = vCnt_r;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: three builds (default, small raster with active-high sync,
// one clock per pixel) checked each cycle against an arithmetic raster model plus directed checks.
module tb_display_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rstA = 1'b1, rstB = 1'b1, rstC = 1'b1;
  logic tickA, hsA, vsA, voA, fsA;
  logic tickB, hsB, vsB, voB, fsB;
  logic tickC, hsC, vsC, voC, fsC;
  logic [9:0] colA, rowA, colB, rowB, colC, rowC;

  display_timing_gen dutA (
    .clk(clk), .reset(rstA), .pixTick(tickA), .pixCol(colA), .pixRow(rowA),
    .horizSync(hsA), .vertSync(vsA), .videoOn(voA), .frameStart(fsA));

  display_timing_gen #(
    .CLK_DIV(3), .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1)
  ) dutB (
    .clk(clk), .reset(rstB), .pixTick(tickB), .pixCol(colB), .pixRow(rowB),
    .horizSync(hsB), .vertSync(vsB), .videoOn(voB), .frameStart(fsB));

  display_timing_gen #(.CLK_DIV(1)) dutC (
    .clk(clk), .reset(rstC), .pixTick(tickC), .pixCol(colC), .pixRow(rowC),
    .horizSync(hsC), .vertSync(vsC), .videoOn(voC), .frameStart(fsC));

  typedef struct {
    int col; int row; int hs; int vs; int vo; int tick; int fs;
  } expT;

  // n = clock edges since reset was released; position is a linear pixel index
  function automatic expT model(int n, int div, int hv, int hf, int hsw, int hb,
                                int vv, int vf, int vsw, int vb, int act);
    expT e;
    int ht, vt, p;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p = (ht * vt - 1 + n / div) % (ht * vt);
    e.col  = p % ht;
    e.row  = p / ht;
    e.tick = (n > 0 && (n % div) == 0) ? 1 : 0;
    e.fs   = (e.tick == 1 && p == 0) ? 1 : 0;
    if (n == 0) begin
      e.hs = 1 - act;
      e.vs = 1 - act;
      e.vo = 0;
    end else begin
      e.hs = (e.col >= hv + hf && e.col < hv + hf + hsw) ? act : 1 - act;
      e.vs = (e.row >= vv + vf && e.row < vv + vf + vsw) ? act : 1 - act;
      e.vo = (e.col < hv && e.row < vv) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmpInst(string tag, expT e, logic [9:0] col, logic [9:0] row,
                         logic hs, logic vs, logic vo, logic tick, logic fs);
    chk({tag, ".pixCol"}, int'(col), e.col);
    chk({tag, ".pixRow"}, int'(row), e.row);
    chk({tag, ".horizSync"}, int'(hs), e.hs);
    chk({tag, ".vertSync"}, int'(vs), e.vs);
    chk({tag, ".videoOn"}, int'(vo), e.vo);
    chk({tag, ".pixTick"}, int'(tick), e.tick);
    chk({tag, ".frameStart"}, int'(fs), e.fs);
  endtask

  int nA = 0, nB = 0, nC = 0;
  bit armed = 1'b0;

  always @(posedge clk) begin
    armed <= 1'b1;
    nA <= rstA ? 0 : nA + 1;
    nB <= rstB ? 0 : nB + 1;
    nC <= rstC ? 0 : nC + 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      cmpInst("modelA", model(nA, 4, 640, 16, 96, 48, 480, 10, 2, 33, 0),
              colA, rowA, hsA, vsA, voA, tickA, fsA);
      cmpInst("modelB", model(nB, 3, 10, 2, 3, 2, 6, 1, 2, 2, 1),
              colB, rowB, hsB, vsB, voB, tickB, fsB);
      cmpInst("modelC", model(nC, 1, 640, 16, 96, 48, 480, 10, 2, 33, 0),
              colC, rowC, hsC, vsC, voC, tickC, fsC);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      begin : branchA
        int hsTicks, hsClks, firstOff, lastCol;
        bit done, prevVo;
        hsTicks = 0; hsClks = 0; firstOff = -1; lastCol = -1; done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("A.reset.pixCol", colA, 799);
        chk("A.reset.pixRow", rowA, 524);
        chk("A.reset.horizSync", hsA, 1);
        chk("A.reset.vertSync", vsA, 1);
        chk("A.reset.videoOn", voA, 0);
        chk("A.reset.pixTick", tickA, 0);
        rstA = 1'b0;
        repeat (3) @(negedge clk);
        chk("A.hold.pixTick", tickA, 0);
        chk("A.hold.pixCol", colA, 799);
        @(negedge clk);
        chk("A.first.pixCol", colA, 0);
        chk("A.first.pixRow", rowA, 0);
        chk("A.first.videoOn", voA, 1);
        chk("A.first.pixTick", tickA, 1);
        chk("A.first.frameStart", fsA, 1);
        repeat (4) @(negedge clk);
        chk("A.second.pixCol", colA, 1);
        chk("A.second.frameStart", fsA, 0);
        prevVo = voA;
        for (int i = 0; i < 4000 && !done; i++) begin
          @(negedge clk);
          if (hsA == 1'b0) hsClks++;
          if (tickA) begin
            if (hsA == 1'b0) hsTicks++;
            if (prevVo && !voA && firstOff < 0) firstOff = colA;
            prevVo = voA;
            if (rowA == 10'd1) done = 1'b1;
            else lastCol = colA;
          end
        end
        chk("A.line.completed", done, 1);
        chk("A.line.videoOffCol", firstOff, 640);
        chk("A.line.hsyncTicks", hsTicks, 96);
        chk("A.line.hsyncClks", hsClks, 384);
        chk("A.line.lastCol", lastCol, 799);
        chk("A.line.wrapCol", colA, 0);
        // the fourth edge after a pixTick cycle is an advance edge; reset it
        repeat (3) @(negedge clk);
        rstA = 1'b1;
        @(negedge clk);
        chk("A.rstOnAdv.pixTick", tickA, 0);
        chk("A.rstOnAdv.pixCol", colA, 799);
        chk("A.rstOnAdv.pixRow", rowA, 524);
        rstA = 1'b0;
        repeat (3) @(negedge clk);
        chk("A.restart.hold", tickA, 0);
        @(negedge clk);
        chk("A.restart.frameStart", fsA, 1);
        chk("A.restart.pixCol", colA, 0);
      end
      begin : branchB
        int ticks, vsTicks, voTicks, voLate;
        bit got, found;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstB = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
          @(negedge clk);
          if (fsB) got = 1'b1;
        end
        chk("B.firstFrameStart", got, 1);
        for (int f = 0; f < 2; f++) begin
          ticks = 1; vsTicks = int'(vsB); voTicks = int'(voB); voLate = 0;
          got = 1'b0;
          for (int i = 0; i < 700 && !got; i++) begin
            @(negedge clk);
            if (tickB) begin
              if (fsB) got = 1'b1;
              else begin
                ticks++;
                if (vsB) vsTicks++;
                if (voB) voTicks++;
                if (voB && rowB >= 10'd6) voLate++;
              end
            end
          end
          chk("B.frame.nextStart", got, 1);
          chk("B.frame.ticks", ticks, 187);
          chk("B.frame.vsyncTicks", vsTicks, 34);
          chk("B.frame.videoTicks", voTicks, 60);
          chk("B.frame.videoLateRows", voLate, 0);
        end
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
          @(negedge clk);
          if (tickB && colB == 10'd13 && rowB == 10'd7) found = 1'b1;
        end
        chk("B.midFrame.reached", found, 1);
        chk("B.midFrame.hsAsserted", hsB, 1);
        chk("B.midFrame.vsAsserted", vsB, 1);
        rstB = 1'b1;
        @(negedge clk);
        chk("B.midReset.pixCol", colB, 16);
        chk("B.midReset.pixRow", rowB, 10);
        chk("B.midReset.horizSync", hsB, 0);
        chk("B.midReset.vertSync", vsB, 0);
        chk("B.midReset.videoOn", voB, 0);
        chk("B.midReset.pixTick", tickB, 0);
        @(negedge clk);
        rstB = 1'b0;
        repeat (2) @(negedge clk);
        chk("B.restart.hold", tickB, 0);
        @(negedge clk);
        chk("B.restart.pixCol", colB, 0);
        chk("B.restart.pixRow", rowB, 0);
        chk("B.restart.frameStart", fsB, 1);
      end
      begin : branchC
        int missing, hsClks, firstCol0, row1Col0;
        missing = 0; hsClks = 0; firstCol0 = -1; row1Col0 = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstC = 1'b0;
        for (int i = 1; i <= 1700; i++) begin
          @(negedge clk);
          if (!tickC) missing++;
          if (hsC == 1'b0 && rowC == 10'd0) hsClks++;
          if (colC == 10'd0 && rowC == 10'd0 && firstCol0 < 0) firstCol0 = i;
          if (colC == 10'd0 && rowC == 10'd1 && row1Col0 < 0) row1Col0 = i;
        end
        chk("C.tickEveryClk", missing, 0);
        chk("C.firstAdvance", firstCol0, 1);
        chk("C.lineClks", row1Col0 - firstCol0, 800);
        chk("C.hsyncClks", hsClks, 96);
      end
    join
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
